// File: rtl/tensor_pkg.sv
// Shared constants, FSM state type and operand unpacking for the 4x4x4 MAC tile.
package tensor_pkg;

    localparam int unsigned DW  = 4;
    localparam int unsigned DIM = 4;
    localparam int unsigned AW  = 16;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        OUT,
        DONE
    } state_t;

    // Row 0 lives in the most significant nibble of each column word.
    function automatic logic [DW-1:0] unpack_elem(input logic [DIM*DW-1:0] word,
                                                  input int unsigned row);
        return word[DW*(DIM-1-row) +: DW];
    endfunction

endpackage

// File: rtl/tensor_mac_pe.sv
// Single signed multiply-accumulate cell of the crossbar; init loads the C element.
module tensor_mac_pe
    import tensor_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    output logic [AW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic        [AW-1:0]   prod_ext;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (init) begin
            acc <= {{(AW-DW){c[DW-1]}}, c};
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/tensor_crossbar_array_4m4n4k.sv
// 4x4x4 signed tile computing D = A*B + C as four outer products, then streaming rows of D.
module tensor_crossbar_array_4m4n4k
    import tensor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cin_M_0,
    input  logic [15:0] cin_M_1,
    input  logic [15:0] cin_M_2,
    input  logic [15:0] cin_M_3,
    input  logic [15:0] cin_N_0,
    input  logic [15:0] cin_N_1,
    input  logic [15:0] cin_N_2,
    input  logic [15:0] cin_N_3,
    input  logic [15:0] cin_K_0,
    input  logic [15:0] cin_K_1,
    input  logic [15:0] cin_K_2,
    input  logic [15:0] cin_K_3,
    output logic [15:0] data_out_col_0,
    output logic [15:0] data_out_col_1,
    output logic [15:0] data_out_col_2,
    output logic [15:0] data_out_col_3
);

    logic [DIM*DW-1:0] m_col [DIM];
    logic [DIM*DW-1:0] n_col [DIM];
    logic [DIM*DW-1:0] k_col [DIM];

    assign m_col[0] = cin_M_0;
    assign m_col[1] = cin_M_1;
    assign m_col[2] = cin_M_2;
    assign m_col[3] = cin_M_3;
    assign n_col[0] = cin_N_0;
    assign n_col[1] = cin_N_1;
    assign n_col[2] = cin_N_2;
    assign n_col[3] = cin_N_3;
    assign k_col[0] = cin_K_0;
    assign k_col[1] = cin_K_1;
    assign k_col[2] = cin_K_2;
    assign k_col[3] = cin_K_3;

    state_t        state_q;
    logic [1:0]    k_q;
    logic [1:0]    r_q;
    logic [DW-1:0] a_q    [DIM][DIM];  // a_q[i][k] = A[i][k]
    logic [DW-1:0] b_q    [DIM][DIM];  // b_q[k][j] = B[k][j]
    logic [AW-1:0] dout_q [DIM];
    logic [AW-1:0] acc    [DIM][DIM];

    logic          pe_init;
    logic          pe_en;
    logic [DW-1:0] a_bus  [DIM];
    logic [DW-1:0] b_bus  [DIM];
    logic [DW-1:0] c_elem [DIM][DIM];

    // C goes straight from the inputs into the accumulators on the start edge.
    assign pe_init = (state_q == IDLE) && start;
    assign pe_en   = (state_q == COMPUTE);

    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            a_bus[i] = a_q[i][k_q];
            b_bus[i] = b_q[k_q][i];
            for (int j = 0; j < DIM; j++) begin
                c_elem[i][j] = unpack_elem(k_col[j], i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            r_q     <= '0;
            for (int i = 0; i < DIM; i++) begin
                dout_q[i] <= '0;
                for (int j = 0; j < DIM; j++) begin
                    a_q[i][j] <= '0;
                    b_q[i][j] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    for (int j = 0; j < DIM; j++) dout_q[j] <= '0;
                    if (start) begin
                        for (int i = 0; i < DIM; i++) begin
                            for (int j = 0; j < DIM; j++) begin
                                a_q[i][j] <= unpack_elem(m_col[j], i);
                                b_q[i][j] <= unpack_elem(n_col[j], i);
                            end
                        end
                        k_q     <= '0;
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    k_q <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        r_q     <= '0;
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    for (int j = 0; j < DIM; j++) dout_q[j] <= acc[r_q][j];
                    r_q <= r_q + 2'd1;
                    if (r_q == 2'd3) state_q <= DONE;
                end
                DONE: begin
                    for (int j = 0; j < DIM; j++) dout_q[j] <= '0;
                    if (!start) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            tensor_mac_pe u_pe (
                .clk  (clk),
                .rst  (rst),
                .init (pe_init),
                .en   (pe_en),
                .a    (a_bus[gi]),
                .b    (b_bus[gj]),
                .c    (c_elem[gi][gj]),
                .acc  (acc[gi][gj])
            );
        end
    end

    assign data_out_col_0 = dout_q[0];
    assign data_out_col_1 = dout_q[1];
    assign data_out_col_2 = dout_q[2];
    assign data_out_col_3 = dout_q[3];

endmodule

// File: tb/tb_tensor_crossbar_array_4m4n4k.sv
// Scoreboard bench: stimulus queues expected rows by cycle; monitor checks outputs every cycle.
module tb_tensor_crossbar_array_4m4n4k;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] m_in [4];
    logic [15:0] n_in [4];
    logic [15:0] k_in [4];
    logic [15:0] d0, d1, d2, d3;

    tensor_crossbar_array_4m4n4k dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cin_M_0        (m_in[0]),
        .cin_M_1        (m_in[1]),
        .cin_M_2        (m_in[2]),
        .cin_M_3        (m_in[3]),
        .cin_N_0        (n_in[0]),
        .cin_N_1        (n_in[1]),
        .cin_N_2        (n_in[2]),
        .cin_N_3        (n_in[3]),
        .cin_K_0        (k_in[0]),
        .cin_K_1        (k_in[1]),
        .cin_K_2        (k_in[2]),
        .cin_K_3        (k_in[3]),
        .data_out_col_0 (d0),
        .data_out_col_1 (d1),
        .data_out_col_2 (d2),
        .data_out_col_3 (d3)
    );

    typedef struct packed {
        int unsigned cyc;
        logic [63:0] row;
    } exp_t;

    exp_t        sb [$];
    int unsigned cyc;
    int          tests;
    int          fails;

    logic [15:0] vm [4][4];
    logic [15:0] vn [4][4];
    logic [15:0] vk [4][4];
    logic [63:0] ve [4][4];

    localparam int VREF = 0;
    localparam int VID  = 1;
    localparam int VEX1 = 2;
    localparam int VEX2 = 3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Outputs must be zero on every cycle that has no queued row.
    always @(negedge clk) begin
        logic [63:0] act;
        logic [63:0] want;
        string       what;
        act  = {d0, d1, d2, d3};
        want = '0;
        what = "zero";
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            want = sb[0].row;
            what = "row";
            void'(sb.pop_front());
        end
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got %h required %h", what, cyc, act, want);
        end
    end

    task automatic apply(input int v);
        for (int c = 0; c < 4; c++) begin
            m_in[c] = vm[v][c];
            n_in[c] = vn[v][c];
            k_in[c] = vk[v][c];
        end
    endtask

    task automatic push_rows(input int v, input int unsigned n, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            exp_t e;
            e.cyc = n + 6 + r;
            e.row = ve[v][r];
            sb.push_back(e);
        end
    endtask

    // Raise start for one edge; returns the cycle count before the start edge.
    task automatic pulse_start(input int v, input int nrows, output int unsigned n);
        @(negedge clk);
        #1;
        apply(v);
        start = 1'b1;
        n = cyc;
        push_rows(v, n, nrows);
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int unsigned n;
        tests = 0;
        fails = 0;

        vm[VREF] = '{16'h2F69, 16'hD4B7, 16'h591C, 16'h63E0};
        vn[VREF] = '{16'h3A5C, 16'hE4F6, 16'h1909, 16'hB2D7};
        vk[VREF] = '{16'h5B4B, 16'hC3D3, 16'h4D4C, 16'hB3C4};
        ve[VREF] = '{64'h001E_000B_FFF1_0006, 64'hFFB1_002E_FFCB_003A,
                     64'h0041_FFD0_003B_FFC3, 64'hFFA8_0031_FFC4_0041};
        vm[VID]  = '{16'h1000, 16'h0100, 16'h0010, 16'h0001};
        vn[VID]  = '{16'h1234, 16'h5670, 16'h9ABC, 16'hDEF0};
        vk[VID]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        ve[VID]  = '{64'h0001_0005_FFF9_FFFD, 64'h0002_0006_FFFA_FFFE,
                     64'h0003_0007_FFFB_FFFF, 64'h0004_0000_FFFC_0000};
        vm[VEX1] = '{16'h8888, 16'h8888, 16'h8888, 16'h8888};
        vn[VEX1] = '{16'h8888, 16'h8888, 16'h8888, 16'h8888};
        vk[VEX1] = '{16'h7777, 16'h7777, 16'h7777, 16'h7777};
        ve[VEX1] = '{64'h0107_0107_0107_0107, 64'h0107_0107_0107_0107,
                     64'h0107_0107_0107_0107, 64'h0107_0107_0107_0107};
        vm[VEX2] = '{16'h8888, 16'h8888, 16'h8888, 16'h8888};
        vn[VEX2] = '{16'h7777, 16'h7777, 16'h7777, 16'h7777};
        vk[VEX2] = '{16'h8888, 16'h8888, 16'h8888, 16'h8888};
        ve[VEX2] = '{64'hFF18_FF18_FF18_FF18, 64'hFF18_FF18_FF18_FF18,
                     64'hFF18_FF18_FF18_FF18, 64'hFF18_FF18_FF18_FF18};

        start = 1'b0;
        apply(VREF);
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic operations
        pulse_start(VREF, 4, n);
        repeat (12) @(negedge clk);
        pulse_start(VID, 4, n);
        repeat (12) @(negedge clk);
        pulse_start(VEX1, 4, n);
        repeat (12) @(negedge clk);
        pulse_start(VEX2, 4, n);
        repeat (12) @(negedge clk);

        // Start held high: a single burst, then a fresh start after a low period
        @(negedge clk);
        #1;
        apply(VID);
        start = 1'b1;
        n = cyc;
        push_rows(VID, n, 4);
        repeat (30) @(negedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start(VREF, 4, n);
        repeat (12) @(negedge clk);

        // Operand changes during COMPUTE are ignored
        pulse_start(VREF, 4, n);
        apply(VEX2);
        repeat (12) @(negedge clk);

        // Reset at E2 aborts; a fresh run afterwards is clean
        pulse_start(VEX1, 0, n);
        wait (cyc == n + 3);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start(VREF, 4, n);
        repeat (12) @(negedge clk);

        // Reset during the OUT window clears outputs without waiting for a clock
        pulse_start(VEX2, 1, n);
        wait (cyc == n + 7);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start(VID, 4, n);
        repeat (12) @(negedge clk);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drained got %0d pending rows required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
